// File: rtl/input_debounce_sync_if.sv
// Board-input bundle: raw switch levels in, debounced levels and rising ticks out.
// The board/bench side is the master, the conditioner is the slave.
interface input_debounce_sync_if;
  logic sw_a;
  logic sw_b;
  logic a;
  logic b;
  logic a_rise;
  logic b_rise;

  modport master (
    output sw_a, sw_b,
    input  a, b, a_rise, b_rise
  );

  modport slave (
    input  sw_a, sw_b,
    output a, b, a_rise, b_rise
  );
endinterface

// File: rtl/input_debounce_sync.sv
// Two independent switch conditioners: 2-FF synchronizer feeding a ZERO/WAIT1/ONE/WAIT0
// debounce FSM that accepts a level only after DB_CYCLES stable synchronized cycles.
module input_debounce_sync #(
  parameter int DB_CYCLES = 2_000_000,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input_debounce_sync_if.slave  io
);

  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0] raw;
  logic [1:0] lvl;
  logic [1:0] rise;

  assign raw = {io.sw_b, io.sw_a};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic             meta_p0;
    logic             sync_p1;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             x_q;
    logic             rise_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        meta_p0 <= 1'b0;
        sync_p1 <= 1'b0;
        state   <= ZERO;
        cnt     <= '0;
        x_q     <= 1'b0;
        rise_q  <= 1'b0;
      end else begin
        // stage p0 -> p1: synchronizer, nothing between the two flops
        meta_p0 <= raw[ch];
        sync_p1 <= meta_p0;
        rise_q  <= 1'b0;
        // debounce stage: sync_p1 must hold for DB_CYCLES cycles inside WAIT
        case (state)
          ZERO: begin
            if (sync_p1) begin
              state <= WAIT1;
              cnt   <= '0;
            end
          end
          WAIT1: begin
            if (!sync_p1) begin
              state <= ZERO;
            end else if (cnt == CNT_LAST) begin
              state  <= ONE;
              x_q    <= 1'b1;
              rise_q <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ONE: begin
            if (!sync_p1) begin
              state <= WAIT0;
              cnt   <= '0;
            end
          end
          WAIT0: begin
            // an aborted fall returns to ONE without a tick; x never dropped
            if (sync_p1) begin
              state <= ONE;
            end else if (cnt == CNT_LAST) begin
              state <= ZERO;
              x_q   <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= ZERO;
            x_q   <= 1'b0;
          end
        endcase
      end
    end

    assign lvl[ch]  = x_q;
    assign rise[ch] = rise_q;
  end

  assign io.a      = lvl[0];
  assign io.b      = lvl[1];
  assign io.a_rise = rise[0];
  assign io.b_rise = rise[1];

endmodule
